// File: rtl/multiply_tokens.sv
`default_nettype none
// ----------------------------------------------------------------------------
// multiply_tokens : per-channel serial token multiplier (FACTOR outputs per
//                   input '1') with sticky run-length / pending overflow flag
// Revision        : 1.0
// ----------------------------------------------------------------------------
module multiply_tokens #(
  parameter int CHANNELS = 1,
  parameter int FACTOR   = 2,
  parameter int MAX_RUN  = 200,
  parameter int PEND_MAX = MAX_RUN * FACTOR
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] a,
  input  logic                b_ready,
  output logic [CHANNELS-1:0] b,
  output logic [CHANNELS-1:0] overflow,
  output logic                overflow_any
);

  localparam int PW = $clog2(PEND_MAX + FACTOR + 1);
  localparam int RW = $clog2(MAX_RUN + 2);

  localparam logic [PW:0]   C_FACTOR    = (PW+1)'(FACTOR);
  localparam logic [PW:0]   C_PEND_MAX  = (PW+1)'(PEND_MAX);
  localparam logic [RW-1:0] C_RUN_LIMIT = RW'(MAX_RUN);
  localparam logic [RW-1:0] C_RUN_SAT   = RW'(MAX_RUN + 1);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [PW-1:0] pend_q, pend_d;
    logic [RW-1:0] run_q, run_d;
    logic          ovf_q, ovf_d;
    logic          emit;
    logic [PW:0]   pend_sum;

    always_comb begin
      emit     = (a[i] | (pend_q != '0)) & b_ready;
      // One extra bit so an over-capacity total is visible before truncation.
      pend_sum = {1'b0, pend_q} + (a[i] ? C_FACTOR : '0) - {{PW{1'b0}}, emit};
      pend_d   = pend_q;
      run_d    = run_q;
      ovf_d    = ovf_q;
      if (!ovf_q) begin
        pend_d = pend_sum[PW-1:0];
        if (!a[i]) begin
          run_d = '0;
        end else if (run_q != C_RUN_SAT) begin
          run_d = run_q + 1'b1;
        end
        ovf_d = (a[i] & (run_q == C_RUN_LIMIT)) | (pend_sum > C_PEND_MAX);
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        pend_q <= '0;
        run_q  <= '0;
        ovf_q  <= 1'b0;
      end else begin
        pend_q <= pend_d;
        run_q  <= run_d;
        ovf_q  <= ovf_d;
      end
    end

    // An overflowed channel holds its output high until reset.
    assign b[i]        = rst_n & (ovf_q | emit);
    assign overflow[i] = ovf_q;
  end

  assign overflow_any = |overflow;

endmodule
`default_nettype wire

// File: tb/tb_multiply_tokens.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_multiply_tokens : randomized + directed bench with a token-count model
// Revision           : 1.0
// ----------------------------------------------------------------------------
module tb_multiply_tokens;

  localparam int MAX_RUN = 200;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] a_all = '0;   // [0]=u0, [1]=u1, [5:2]=u2 channels 0..3
  logic [2:0] rdy   = '0;

  logic       b0, ovf0, any0;
  logic       b1, ovf1, any1;
  logic [3:0] b2, ovf2;
  logic       any2;
  logic [5:0] b_all, ovf_all;

  assign b_all   = {b2, b1, b0};
  assign ovf_all = {ovf2, ovf1, ovf0};

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  multiply_tokens u0 (
    .clk(clk), .rst_n(rst_n), .a(a_all[0]), .b_ready(rdy[0]),
    .b(b0), .overflow(ovf0), .overflow_any(any0)
  );

  multiply_tokens #(.FACTOR(3)) u1 (
    .clk(clk), .rst_n(rst_n), .a(a_all[1]), .b_ready(rdy[1]),
    .b(b1), .overflow(ovf1), .overflow_any(any1)
  );

  multiply_tokens #(.CHANNELS(4)) u2 (
    .clk(clk), .rst_n(rst_n), .a(a_all[5:2]), .b_ready(rdy[2]),
    .b(b2), .overflow(ovf2), .overflow_any(any2)
  );

  // Reference: tokens owed, current run length and error flag per channel.
  int owed [6];
  int runl [6];
  bit err  [6];

  function automatic int fac(input int k);
    return (k == 1) ? 3 : 2;
  endfunction

  function automatic int inst(input int k);
    return (k == 0) ? 0 : ((k == 1) ? 1 : 2);
  endfunction

  function automatic bit exp_b(input int k);
    if (!rst_n) return 1'b0;
    if (err[k]) return 1'b1;
    return rdy[inst(k)] && (a_all[k] || owed[k] > 0);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic step_model();
    bit e [6];
    for (int k = 0; k < 6; k++) e[k] = exp_b(k);
    for (int k = 0; k < 6; k++) begin
      if (!err[k]) begin
        int nxt;
        nxt = owed[k] + (a_all[k] ? fac(k) : 0) - (e[k] ? 1 : 0);
        if ((a_all[k] && runl[k] == MAX_RUN) || nxt > fac(k) * MAX_RUN) begin
          err[k] = 1'b1;
        end else begin
          owed[k] = nxt;
          runl[k] = a_all[k] ? ((runl[k] + 1 > MAX_RUN + 1) ? MAX_RUN + 1 : runl[k] + 1) : 0;
        end
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        for (int k = 0; k < 6; k++) begin
          owed[k] = 0;
          runl[k] = 0;
          err[k]  = 1'b0;
        end
      end else begin
        step_model();
      end
    end
  end

  // Every-cycle compare against the model.
  initial begin
    forever begin
      @(negedge clk);
      for (int k = 0; k < 6; k++) begin
        check($sformatf("b[%0d]", k), int'(b_all[k]), int'(exp_b(k)));
        check($sformatf("ovf[%0d]", k), int'(ovf_all[k]), int'(err[k]));
      end
      check("any0", int'(any0), int'(err[0]));
      check("any1", int'(any1), int'(err[1]));
      check("any2", int'(any2), int'(err[2] | err[3] | err[4] | err[5]));
    end
  end

  task automatic rand_u1();
    a_all[1] = ($urandom_range(0, 2) == 0);
    rdy[1]   = ($urandom_range(0, 3) != 0);
  endtask

  task automatic rand_u2();
    a_all[5:2] = 4'($urandom);
    rdy[2]     = ($urandom_range(0, 3) != 0);
  endtask

  task automatic pulse_reset(input string name);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check({name, "_b0"}, int'(b0), 0);
    check({name, "_ovf0"}, int'(ovf0), 0);
    check({name, "_any0"}, int'(any0), 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
  endtask

  logic [25:0] pat_a = 26'b10010011000110100001100100;
  logic [25:0] pat_b = 26'b11011011110111111001111110;
  logic [6:0]  f3_b  = 7'b1110000;
  logic [5:0]  bp_b  = 6'b000110;
  int          f3_p [4] = '{0, 2, 1, 0};
  int          hi0;

  initial begin
    // Reset: outputs forced low even with every input asserted.
    a_all = '1;
    rdy   = '1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_b", int'(b_all), 0);
    check("rst_ovf", int'(ovf_all), 0);
    check("rst_any", int'({any2, any1, any0}), 0);
    @(posedge clk);
    #3;
    a_all = '0;
    rdy   = '0;
    rst_n = 1'b1;

    // Pattern on u0, FACTOR=3 pulse on u1, start a long run on u2 channel 2.
    for (int t = 0; t < 26; t++) begin
      @(posedge clk); #1;
      a_all[0]   = pat_a[25-t];
      rdy[0]     = 1'b1;
      a_all[1]   = (t == 0);
      rdy[1]     = 1'b1;
      a_all[5:2] = 4'b0100;
      rdy[2]     = 1'b1;
      @(negedge clk);
      check("pat_b0", int'(b0), int'(pat_b[25-t]));
      if (t < 7) check("f3_b1", int'(b1), int'(f3_b[6-t]));
      if (t < 4) check("f3_pend_model", owed[1], f3_p[t]);
    end

    // u0: legal 200-long run; u2: ch2 reaches 201 ones while 0,1,3 run the pattern.
    hi0 = 0;
    for (int t = 0; t < 200; t++) begin
      @(posedge clk); #1;
      a_all[0] = 1'b1;
      rdy[0]   = 1'b1;
      rand_u1();
      a_all[4] = (t < 175);
      if (t >= 160 && t < 186) begin
        a_all[2] = pat_a[25-(t-160)];
        a_all[3] = pat_a[25-(t-160)];
        a_all[5] = pat_a[25-(t-160)];
      end else begin
        a_all[2] = 1'b0;
        a_all[3] = 1'b0;
        a_all[5] = 1'b0;
      end
      rdy[2] = 1'b1;
      @(negedge clk);
      hi0 += int'(b0);
      if (t >= 160 && t < 186) begin
        check("ch0_pat", int'(b2[0]), int'(pat_b[25-(t-160)]));
        check("ch1_pat", int'(b2[1]), int'(pat_b[25-(t-160)]));
        check("ch3_pat", int'(b2[3]), int'(pat_b[25-(t-160)]));
      end
      if (t == 174) check("ch2_ovf_pre", int'(ovf2), 0);
      if (t == 175) begin
        check("ch2_ovf_set", int'(ovf2), 4);
        check("ch2_any_set", int'(any2), 1);
      end
    end

    for (int t = 0; t < 250; t++) begin
      @(posedge clk); #1;
      a_all[0] = 1'b0;
      rdy[0]   = 1'b1;
      rand_u1();
      rand_u2();
      @(negedge clk);
      hi0 += int'(b0);
      if (t == 199) check("drain_last", int'(b0), 1);
      if (t == 200) check("drain_done", int'(b0), 0);
    end
    check("run200_high", hi0, 400);
    check("run200_ovf", int'(ovf0), 0);

    // Run of 201 ones overflows; flag and b stay high through 50 idle cycles.
    hi0 = 0;
    for (int t = 0; t < 251; t++) begin
      @(posedge clk); #1;
      a_all[0] = (t < 201);
      rdy[0]   = 1'b1;
      rand_u1();
      rand_u2();
      @(negedge clk);
      if (t == 200) check("run201_pre", int'(ovf0), 0);
      if (t == 201) check("run201_set", int'(ovf0), 1);
      if (t >= 201) hi0 += int'(b0 & ovf0);
    end
    check("ovf_hold", hi0, 50);
    pulse_reset("rst1");

    // Backpressure: one token held for three stalled cycles, then released.
    for (int t = 0; t < 6; t++) begin
      @(posedge clk); #1;
      a_all[0] = (t == 0);
      rdy[0]   = (t >= 3);
      rand_u1();
      rand_u2();
      @(negedge clk);
      check("bp_b0", int'(b0), int'(bp_b[5-t]));
    end

    // Stalled, alternating input: pend crosses capacity on the 201st token.
    for (int t = 0; t < 402; t++) begin
      @(posedge clk); #1;
      a_all[0] = (t % 2 == 0);
      rdy[0]   = 1'b0;
      rand_u1();
      rand_u2();
      @(negedge clk);
      if (t == 400) check("pend_ovf_pre", int'(ovf0), 0);
      if (t == 401) check("pend_ovf_set", int'(ovf0), 1);
    end
    pulse_reset("rst2");

    // Build pend=5, then reset asynchronously mid-cycle.
    for (int t = 0; t < 4; t++) begin
      @(posedge clk); #1;
      a_all[0] = (t < 3);
      rdy[0]   = (t == 3);
      rand_u1();
      rand_u2();
    end
    @(posedge clk); #1;
    a_all[0] = 1'b0;
    rdy[0]   = 1'b1;
    check("mid_pend_model", owed[0], 5);
    check("mid_b_before", int'(b0), 1);
    #2 rst_n = 1'b0;
    #1 check("mid_b_reset", int'(b0), 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    for (int t = 0; t < 5; t++) begin
      @(posedge clk); #1;
      a_all[0] = 1'b0;
      rdy[0]   = 1'b1;
      @(negedge clk);
      check("post_rst_b0", int'(b0), 0);
    end

    // Free-running random traffic on every channel.
    for (int t = 0; t < 800; t++) begin
      @(posedge clk); #1;
      a_all[0] = $urandom_range(0, 1) == 1;
      rdy[0]   = ($urandom_range(0, 3) != 0);
      rand_u1();
      rand_u2();
    end
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/multiply_tokens.md
# multiply_tokens

Serial per-channel token multiplier, the parametrised successor of the two-times token doubler in the sequential-basics set. Every '1' sampled on a channel input is turned into FACTOR output '1's, issued one per cycle, with the first copy issued combinationally in the same cycle. Channels are independent and share one output-ready qualifier. Each channel has a sticky overflow flag, set on an over-long input run or on pending-count exhaustion.

## Interface
- CHANNELS, 1: number of independent token channels (≥1).
- FACTOR, 2: output '1's per input '1' (≥1; FACTOR=1 is pass-through).
- MAX_RUN, 200: longest legal run of consecutive input '1's per channel.
- PEND_MAX, MAX_RUN*FACTOR: capacity of each channel's pending counter.
- Counter width PW = $clog2(PEND_MAX+FACTOR+1); run width RW = $clog2(MAX_RUN+2).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- a  in  CHANNELS  input token stream, one bit per channel per cycle.
- b_ready  in  1  downstream accepts an output token this cycle; common to all channels.
- b  out  CHANNELS  output token stream.
- overflow  out  CHANNELS  per-channel sticky error flag.
- overflow_any  out  1  OR of overflow.

## Operation
Each channel i holds three registers:
- pend[i] (PW bits): output '1's owed.
- run[i] (RW bits): current consecutive-'1' count, saturating at MAX_RUN+1.
- ovf[i]: sticky overflow flag.

Per channel, each cycle, when ovf[i]=0:
- want = a[i] | (pend[i] != 0).
- emit = want & b_ready.
- b[i] = emit.
- pend_next = pend[i] + (a[i] ? FACTOR : 0) − (emit ? 1 : 0).
  - Compute at PW+1 bits; the result is never negative.
  - With b_ready=1, a sampled '1' therefore contributes one immediate output plus FACTOR−1 deferred outputs.
- run_next = a[i] ? min(run[i]+1, MAX_RUN+1) : 0.

Overflow set condition, evaluated at the clock edge: a[i]=1 and run[i]==MAX_RUN (the (MAX_RUN+1)-th consecutive '1' is being sampled), or pend_next > PEND_MAX.

While ovf[i]=1:
- b[i]=1 constantly, regardless of a and b_ready.
- pend[i] and run[i] are frozen.
- Only rst_n clears the flag.

Other rules:
- b_ready=0 stalls emission only. Input tokens are still counted into pend.
- Channels never interact. Overflow on one channel does not affect the others.
- FACTOR=1 with b_ready=1: b equals a, and pend stays 0.

## Timing
- Reset (rst_n=0, asynchronous): pend=0, run=0, ovf=0 for all channels. Outputs during reset: b=0 (forced, independent of a), overflow=0, overflow_any=0.
- Reset release: the first rising edge with rst_n=1 is the first sampling edge.
- Reset asserted mid-burst: pending tokens are discarded, and b drops to 0 immediately.
- Latency:
  - The first copy of a token appears on b in the same cycle as a, combinationally, when b_ready=1.
  - The remaining copies appear on subsequent ready cycles.
- b depends combinationally on a, b_ready and registered state. There is no combinational path to overflow.
- overflow rises in the cycle after the offending edge and stays high until reset.
- Simultaneous events:
  - a=1 with pend>0 emits one token and adds FACTOR.
  - a=1 with b_ready=0 adds FACTOR and emits nothing.
- Boundary conditions:
  - A run of exactly MAX_RUN '1's is legal. A run of MAX_RUN+1 sets the flag.
  - pend_next == PEND_MAX is legal; PEND_MAX+1 sets the flag.

## Test plan
- Default parameters (CHANNELS=1, FACTOR=2), b_ready=1:
  - a=10010011000110100001100100 → b=11011011110111111001111110.
  - overflow stays 0.
- FACTOR=3, b_ready=1, single pulse a=1000000 → b=1110000, with pend sequence 0,2,1,0.
- Run-length boundary at defaults:
  - 200 consecutive '1's then 0s → no overflow; b high for 400 cycles, then low.
  - 201 consecutive '1's → overflow=1 from the cycle after the 201st '1'.
  - The flag stays 1 while a=0 for 50 cycles, and b stays 1 throughout.
  - rst_n pulse → overflow=0, b=0.
- Backpressure, FACTOR=2:
  - a=1 for one cycle with b_ready=0 for 3 cycles → b=000.
  - Then b_ready=1 → b=11, then 0.
  - Hold b_ready=0 with a long enough that pend would exceed PEND_MAX → overflow set on exactly that edge.
- CHANNELS=4:
  - Drive channel 2 into overflow while channels 0, 1, 3 run the pattern from the first scenario → only overflow[2] and overflow_any rise; the other channels' b matches the expected output bit-exactly.
- Reset mid-operation:
  - Assert rst_n=0 asynchronously, between clock edges, while pend=5 → b=0 immediately.
  - After release with a=0 → b stays 0.
